// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: LSB-first full-adder stepping, parallel result and DONE pulse.
// Optional signed-overflow flag is enabled with `define SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF
);

    // state  | meaning
    // IDLE   | waiting for START, outputs hold the last result
    // SHIFT  | one full-adder step per cycle, WIDTH cycles
    // FIN    | DONE cycle, result/flags already valid
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s_bit;
    logic               c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        s_bit    = sa_q[0] ^ sb_q[0] ^ c_q;
        c_next   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sa_d    = A_IN;
                    sb_d    = SUB ? ~B_IN : B_IN;
                    c_d     = SUB;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                acc_d = {s_bit, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Publish on entry to FIN so outputs are valid alongside DONE.
                    result_d = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d   = c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d    = c_q ^ c_next;
`endif
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign COUT   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign OVF    = ovf_q;
`else
    assign OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: arithmetic reference model checked every cycle plus directed literal cases.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .SUB    (sub),
        .A_IN   (a_in),
        .B_IN   (b_in),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result),
        .COUT   (cout),
        .OVF    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an accepted op keeps the block busy WIDTH+1 cycles, DONE on the last.
    int               m_rem = 0;
    logic [WIDTH-1:0] m_res = '0, p_res = '0;
    logic             m_cout = 0, p_cout = 0;
    logic             m_ovf = 0, p_ovf = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_res = '0; m_cout = 0; m_ovf = 0;
        end else if (m_rem > 0) begin
            if (m_rem == 2) begin
                m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
            end
            m_rem--;
        end else if (start) begin
            int ai, bi, sa, sb, sr;
            ai = int'(a_in);
            bi = int'(b_in);
            sa = int'($signed(a_in));
            sb = int'($signed(b_in));
            if (sub) begin
                p_res  = WIDTH'((ai - bi) & 255);
                p_cout = (ai >= bi);
                sr     = sa - sb;
            end else begin
                p_res  = WIDTH'((ai + bi) & 255);
                p_cout = (ai + bi) > 255;
                sr     = sa + sb;
            end
`ifdef SERIAL_ADDSUB_OVF_EN
            p_ovf = (sr > 127) || (sr < -128);
`else
            p_ovf = 1'b0;
`endif
            m_rem = WIDTH + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(busy),   32'(m_rem > 0));
            chk("done",   32'(done),   32'(m_rem == 1));
            chk("result", 32'(result), 32'(m_res));
            chk("cout",   32'(cout),   32'(m_cout));
            chk("ovf",    32'(ovf),    32'(m_ovf));
        end
    end

    // One op: pulse START, scramble operands mid-op, wait (bounded) for DONE and check latency.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input bit lit, input logic [7:0] er, input logic ec,
                          input logic eo, input string nm);
        int n;
        @(posedge clk); #2;
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); sub = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk({nm, "_latency"}, 32'(n), 32'd9);
        if (lit) begin
            chk({nm, "_result"}, 32'(result), 32'(er));
            chk({nm, "_cout"},   32'(cout),   32'(ec));
            chk({nm, "_ovf"},    32'(ovf),    32'(eo));
        end
    endtask

    logic exp_ovf_7f;
    int   last_done, gaps_bad, n_done;

    initial begin
`ifdef SERIAL_ADDSUB_OVF_EN
        exp_ovf_7f = 1'b1;
`else
        exp_ovf_7f = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        @(posedge clk); @(posedge clk); #2;
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1, 8'h08, 1'b0, 1'b0, "add_5_3");
        run_op(8'h05, 8'h03, 1'b1, 1, 8'h02, 1'b1, 1'b0, "sub_5_3");
        run_op(8'h03, 8'h05, 1'b1, 1, 8'hFE, 1'b0, 1'b0, "sub_3_5");
        run_op(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, exp_ovf_7f, "add_7f_1");
        run_op(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0, "add_ff_1");
        run_op(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, exp_ovf_7f, "sub_80_1");

        // START held high with operands changing every cycle.
        @(posedge clk); #2;
        start = 1'b1;
        last_done = -1; gaps_bad = 0; n_done = 0;
        for (int i = 0; i < 62; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); sub = 1'($urandom);
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && i - last_done != 10) gaps_bad++;
                last_done = i;
                n_done++;
            end
            @(posedge clk); #2;
        end
        start = 1'b0;
        chk("held_start_gaps",  32'(gaps_bad), 32'd0);
        chk("held_start_dones", 32'(n_done),   32'd6);
        repeat (12) @(posedge clk);

        // Reset during the 4th SHIFT cycle.
        run_op(8'h05, 8'h03, 1'b0, 1, 8'h08, 1'b0, 1'b0, "pre_abort");
        @(posedge clk); #2;
        a_in = 8'h11; b_in = 8'h22; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_op(8'h20, 8'h0A, 1'b1, 1, 8'h16, 1'b1, 1'b0, "post_abort");

        for (int i = 0; i < 1000; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 8'h00, 1'b0, 1'b0, "rand");

        @(posedge clk); @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
